pipe_reg_chain: RTL and testbench

Parametrised elastic pipeline register chain: NSTAGES stages of WIDTH-bit data, each with its own valid bit and a val/rdy handshake on both ends. It replaces hand-chained enable/reset registers between predictor pipeline stages (fetch → predict → update). It adds bubble collapsing, backpressure and a global squash (flush) for branch mispredict recovery.

---
 rtl/pipe_reg_pkg.sv | 7 +
 rtl/pipe_reg_stage.sv | 34 +++
 rtl/pipe_reg_chain.sv | 70 +++++++
 tb/tb_pipe_reg_chain.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: shared sizing helpers and limits for the pipeline register chain
package pipe_reg_pkg;
  localparam int PIPE_REG_MIN_STAGES = 1;
  function automatic int occ_width(input int n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one elastic stage holding a valid bit and a data word
module pipe_reg_stage #(
  parameter int               p_nbits       = 32,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               en_i,
  input  logic               vin_i,
  input  logic [p_nbits-1:0] din_i,
  output logic               val_o,
  output logic [p_nbits-1:0] dout_o
);
  logic               val_q, val_d;
  logic [p_nbits-1:0] data_q, data_d;
  // Flush empties the stage; data only changes when a valid word enters, so bubbles never clobber it.
  always_comb begin
    val_d  = flush ? 1'b0 : (en_i ? vin_i : val_q);
    data_d = (en_i && vin_i && !flush) ? din_i : data_q;
  end
  // Asynchronous active-low reset returns the stage to empty with the reset data value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q  <= 1'b0;
      data_q <= p_reset_value;
    end else begin
      val_q  <= val_d;
      data_q <= data_d;
    end
  end
  assign val_o  = val_q;
  assign dout_o = data_q;
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic val/rdy register chain with bubble collapse and flush; PIPE_REG_CHAIN_OCC_EN adds an occupancy counter
module pipe_reg_chain
  import pipe_reg_pkg::*;
#(
  parameter int                 p_nbits       = 32,
  parameter int                 p_nstages     = 2,
  parameter logic [p_nbits-1:0] p_reset_value = '0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                flush,
  input  logic                                in_val,
  output logic                                in_rdy,
  input  logic [p_nbits-1:0]                  in_msg,
  output logic                                out_val,
  input  logic                                out_rdy,
  output logic [p_nbits-1:0]                  out_msg,
  output logic [occ_width(p_nstages)-1:0]     occ
);
  logic [p_nstages-1:0] val, en;
  logic [p_nbits-1:0]   dat [p_nstages+1];
  logic                 acc;
  assign dat[0] = in_msg;
  // A stage may load when downstream is ready or any stage at or beyond it is empty.
  always_comb begin
    en  = '0;
    acc = out_rdy;
    for (int k = p_nstages - 1; k >= 0; k--) begin
      acc   = acc || !val[k];
      en[k] = acc;
    end
  end
  for (genvar g = 0; g < p_nstages; g++) begin : g_stage
    logic vin;
    if (g == 0) begin : g_head
      assign vin = in_val && !flush;
    end else begin : g_body
      assign vin = val[g-1];
    end
    pipe_reg_stage #(.p_nbits(p_nbits), .p_reset_value(p_reset_value)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .flush  (flush),
      .en_i   (en[g]),
      .vin_i  (vin),
      .din_i  (dat[g]),
      .val_o  (val[g]),
      .dout_o (dat[g+1])
    );
  end
  assign in_rdy  = en[0] && !flush;
  assign out_val = val[p_nstages-1];
  assign out_msg = dat[p_nstages];
  cfg_min_stages: assert property (@(posedge clk) p_nstages >= PIPE_REG_MIN_STAGES);
`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam int OW = occ_width(p_nstages);
  logic [OW-1:0] occ_q, occ_d;
  // Occupancy follows the fires; flush empties every stage in a single edge.
  always_comb occ_d = flush ? '0 : occ_q + OW'(in_val && in_rdy) - OW'(out_val && out_rdy);
  // Counter shares the chain's asynchronous reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) occ_q <= '0;
    else occ_q <= occ_d;
  end
  assign occ = occ_q;
  occ_matches_valids: assert property (@(posedge clk) disable iff (!reset) occ_q == OW'($countones(val)));
`else
  assign occ = '0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and randomized checks of two chains against a slot-level queue model
module tb_pipe_reg_chain;
  localparam logic [7:0] RV = 8'hA5;
`ifdef PIPE_REG_CHAIN_OCC_EN
  localparam bit OCC = 1'b1;
`else
  localparam bit OCC = 1'b0;
`endif
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_val [2], in_rdy [2], flush [2], out_val [2], out_rdy [2];
  logic [7:0] in_msg [2], out_msg [2];
  logic [1:0] occ0;
  logic       occ1;
  int         checks = 0, errors = 0;
  logic       mv [2][3];
  logic [7:0] md [2][3];
  int         mn [2] = '{3, 1};
  logic       bub_v [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [7:0] bub_m [4] = '{8'h01, 8'h00, 8'h02, 8'h03};

  always #5 clk = ~clk;

  pipe_reg_chain #(.p_nbits(8), .p_nstages(3), .p_reset_value(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush[0]), .in_val(in_val[0]), .in_rdy(in_rdy[0]),
    .in_msg(in_msg[0]), .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0]), .occ(occ0));
  pipe_reg_chain #(.p_nbits(8), .p_nstages(1), .p_reset_value(RV)) dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]), .in_val(in_val[1]), .in_rdy(in_rdy[1]),
    .in_msg(in_msg[1]), .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1]), .occ(occ1));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pop(input int m);
    int c = 0;
    for (int k = 0; k < mn[m]; k++) c += int'(mv[m][k]);
    return c;
  endfunction

  // room exists if any slot is empty or the head is leaving; flush blocks input
  function automatic logic exp_rdy(input int m);
    logic room = out_rdy[m];
    for (int k = 0; k < mn[m]; k++) if (!mv[m][k]) room = 1'b1;
    return room && !flush[m];
  endfunction

  task automatic model_step(input int m);
    int   n = mn[m];
    logic rdy = exp_rdy(m);
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        mv[m][k] = 1'b0;
        md[m][k] = RV;
      end
    end else if (flush[m]) begin
      for (int k = 0; k < 3; k++) mv[m][k] = 1'b0;
    end else begin
      if (out_rdy[m]) mv[m][n-1] = 1'b0;
      for (int k = n - 2; k >= 0; k--)
        if (mv[m][k] && !mv[m][k+1]) begin
          mv[m][k+1] = 1'b1;
          md[m][k+1] = md[m][k];
          mv[m][k]   = 1'b0;
        end
      if (in_val[m] && rdy) begin
        mv[m][0] = 1'b1;
        md[m][0] = in_msg[m];
      end
    end
  endtask

  always @(posedge clk or negedge reset)
    for (int m = 0; m < 2; m++) model_step(m);

  always @(negedge clk)
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("m%0d out_val", m), 32'(out_val[m]), 32'(mv[m][mn[m]-1]));
      chk($sformatf("m%0d out_msg", m), 32'(out_msg[m]), 32'(md[m][mn[m]-1]));
      chk($sformatf("m%0d in_rdy", m), 32'(in_rdy[m]), 32'(exp_rdy(m)));
      chk($sformatf("m%0d occ", m), m == 0 ? 32'(occ0) : 32'(occ1), OCC ? 32'(pop(m)) : 32'd0);
    end

  initial begin
    for (int m = 0; m < 2; m++) begin
      in_val[m] = 1'b0; in_msg[m] = 8'h00; flush[m] = 1'b0; out_rdy[m] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #2;
    chk("rst out_val", 32'(out_val[0]), 32'd0);
    chk("rst out_msg", 32'(out_msg[0]), 32'hA5);
    chk("rst occ", 32'(occ0), 32'd0);
    chk("rst in_rdy", 32'(in_rdy[0]), 32'd1);
    reset = 1'b1;
    out_rdy[0] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      in_val[0] = (k <= 4);
      in_msg[0] = 8'(k);
      @(posedge clk); #2;
      chk("stream out_val", 32'(out_val[0]), 32'(k >= 3 && k <= 6));
      if (k >= 3 && k <= 6) chk("stream out_msg", 32'(out_msg[0]), 32'(k - 2));
    end
    out_rdy[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_val[0] = 1'b1; in_msg[0] = 8'(k);
      @(posedge clk); #2;
    end
    in_msg[0] = 8'h04;
    #1;
    chk("bp full in_rdy", 32'(in_rdy[0]), 32'd0);
    chk("bp full occ", 32'(occ0), OCC ? 32'd3 : 32'd0);
    chk("bp head", 32'(out_msg[0]), 32'h01);
    out_rdy[0] = 1'b1;
    #1;
    chk("bp release in_rdy", 32'(in_rdy[0]), 32'd1);
    @(posedge clk); #2;
    in_val[0] = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      chk("bp drain val", 32'(out_val[0]), 32'd1);
      chk("bp drain msg", 32'(out_msg[0]), 32'(k));
      @(posedge clk); #2;
    end
    chk("bp empty", 32'(out_val[0]), 32'd0);
    out_rdy[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_val[0] = bub_v[k]; in_msg[0] = bub_m[k];
      @(posedge clk); #2;
    end
    in_val[0] = 1'b0;
    chk("bubble occ", 32'(occ0), OCC ? 32'd3 : 32'd0);
    chk("bubble full in_rdy", 32'(in_rdy[0]), 32'd0);
    out_rdy[0] = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk("bubble drain val", 32'(out_val[0]), 32'd1);
      chk("bubble drain msg", 32'(out_msg[0]), 32'(k));
      @(posedge clk); #2;
    end
    chk("bubble empty", 32'(out_val[0]), 32'd0);
    out_rdy[0] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_val[0] = 1'b1; in_msg[0] = 8'(k);
      @(posedge clk); #2;
    end
    in_msg[0] = 8'h77; flush[0] = 1'b1;
    #1;
    chk("flush in_rdy", 32'(in_rdy[0]), 32'd0);
    chk("flush cycle out_val", 32'(out_val[0]), 32'd1);
    @(posedge clk); #2;
    flush[0] = 1'b0; in_val[0] = 1'b0;
    chk("flush out_val", 32'(out_val[0]), 32'd0);
    chk("flush occ", 32'(occ0), 32'd0);
    out_rdy[0] = 1'b1;
    repeat (4) begin
      @(posedge clk); #2;
      chk("flush no 77", 32'(out_val[0]), 32'd0);
    end
    out_rdy[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_val[0] = bub_v[k]; in_msg[0] = bub_m[k];
      @(posedge clk); #2;
    end
    in_val[0] = 1'b0;
    chk("mid pre out_val", 32'(out_val[0]), 32'd1);
    chk("mid pre occ", 32'(occ0), OCC ? 32'd2 : 32'd0);
    reset = 1'b0;
    #1;
    chk("mid rst out_val", 32'(out_val[0]), 32'd0);
    chk("mid rst out_msg", 32'(out_msg[0]), 32'hA5);
    chk("mid rst occ", 32'(occ0), 32'd0);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("post rst in_rdy", 32'(in_rdy[0]), 32'd1);
    out_rdy[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_val[1] = 1'b1; in_msg[1] = 8'(8'h10 + k);
      #1;
      chk("n1 in_rdy", 32'(in_rdy[1]), 32'd1);
      @(posedge clk); #2;
      chk("n1 out_val", 32'(out_val[1]), 32'd1);
      chk("n1 out_msg", 32'(out_msg[1]), 32'(8'h10 + k));
    end
    in_val[1] = 1'b0;
    @(posedge clk); #2;
    chk("n1 empty", 32'(out_val[1]), 32'd0);
    for (int i = 0; i < 3000; i++) begin
      for (int m = 0; m < 2; m++) begin
        in_val[m]  = ($urandom % 4) != 0;
        in_msg[m]  = 8'($urandom);
        out_rdy[m] = ($urandom % 4) < ((i / 500) % 4 + 1);
        flush[m]   = ($urandom % 25) == 0;
      end
      reset = ($urandom % 200) != 0;
      @(posedge clk); #2;
    end
    reset = 1'b1;
    @(posedge clk); #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
